// File: rtl/hades_pio_rule_loader.sv
// hades_pio_rule_loader: turns toggle-strobed PIO nibbles into rule words
// and presents them on a valid/ready port with a status readback byte.
module hades_pio_rule_loader #(
  parameter int WORD_NIBBLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                pio_in,
  output logic [4*WORD_NIBBLES-1:0] rule_data,
  output logic                      rule_valid,
  input  logic                      rule_ready,
  output logic [7:0]                status
);
  localparam int W  = 4 * WORD_NIBBLES;
  localparam int CW = $clog2(WORD_NIBBLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(WORD_NIBBLES - 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_d;
  logic [7:0]    pio_q;
  logic          armed;
  logic          ack_toggle;
  logic          evt;
  logic [CW-1:0] cnt, cnt_d, pos;
  logic [TW-1:0] tmr, tmr_d, tmr_inc;
  logic [W-1:0]  sr, sr_d;
  logic [W+3:0]  shifted;
  logic          done, ferr, terr;
  logic          err_frame, err_ovf, err_timeout;
  logic          load, ovf, clr;
  logic          rsvd_unused;

  assign evt         = armed & (pio_q[7] ^ ack_toggle);
  assign clr         = pio_q[5];
  assign rsvd_unused = pio_q[4];
  assign shifted     = {sr, pio_q[3:0]};
  assign tmr_inc     = tmr + 1'b1;
  assign pos         = (state == IDLE) ? '0 : cnt;

  // Input capture; the strobe level is absorbed until armed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_q      <= '0;
      armed      <= 1'b0;
      ack_toggle <= 1'b0;
    end else begin
      pio_q <= pio_in;
      armed <= 1'b1;
      if (!armed)
        ack_toggle <= pio_in[7];
      else if (evt)
        ack_toggle <= pio_q[7];
    end
  end

  // Frame state register, nibble count, shift register and idle timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      sr    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      tmr   <= tmr_d;
      sr    <= sr_d;
    end
  end

  // Framing decisions per event, timeout while collecting
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sr_d    = sr;
    tmr_d   = '0;
    done    = 1'b0;
    ferr    = 1'b0;
    terr    = 1'b0;
    if (evt) begin
      sr_d = shifted[W-1:0];
      if (pos == LAST_POS) begin
        state_d = IDLE;
        cnt_d   = '0;
        done    = pio_q[6];
        ferr    = ~pio_q[6];
      end else if (pio_q[6]) begin
        state_d = IDLE;
        cnt_d   = '0;
        ferr    = 1'b1;
      end else begin
        state_d = COLLECT;
        cnt_d   = pos + 1'b1;
      end
    end else if (state == COLLECT) begin
      if (tmr_inc == T_LIM) begin
        state_d = IDLE;
        cnt_d   = '0;
        terr    = 1'b1;
      end else begin
        tmr_d = tmr_inc;
      end
    end
  end

  assign load = done & (~rule_valid | rule_ready);
  assign ovf  = done & rule_valid & ~rule_ready;

  // Output holding register with same-cycle consume-and-reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rule_data  <= '0;
      rule_valid <= 1'b0;
    end else if (load) begin
      rule_data  <= sr_d;
      rule_valid <= 1'b1;
    end else if (rule_ready) begin
      rule_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new error beats a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_frame   <= 1'b0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_frame   <= ferr | (err_frame & ~clr);
      err_ovf     <= ovf | (err_ovf & ~clr);
      err_timeout <= terr | (err_timeout & ~clr);
    end
  end

  assign status = {ack_toggle, 2'b00, err_timeout, err_ovf,
                   err_frame, state == COLLECT, rule_valid};

endmodule

// File: tb/tb_hades_pio_rule_loader.sv
// tb_hades_pio_rule_loader: scoreboard bench for the PIO rule loader,
// covering framing, overflow, timeout, reset and simultaneous handshake.
module tb_hades_pio_rule_loader;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pio_in;
  logic [31:0] rule_data;
  logic        rule_valid;
  logic        rule_ready;
  logic [7:0]  status;

  int          total = 0;
  int          bad = 0;
  logic        tog;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  hades_pio_rule_loader #(
    .WORD_NIBBLES(8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pio_in(pio_in),
    .rule_data(rule_data),
    .rule_valid(rule_valid),
    .rule_ready(rule_ready),
    .status(status)
  );

  // Scoreboard: every handshake must match the oldest expected word
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rule_valid === 1'b1 && rule_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h exp=none", rule_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rule_data !== sb_exp) begin
          bad++;
          $display("FAIL sb_word got=%h exp=%h", rule_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, input logic last);
    tog = ~tog;
    pio_in = {tog, last, 2'b00, n};
    step(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_nib(w[4*i +: 4], i == 0);
  endtask

  task automatic clear_err;
    pio_in[5] = 1'b1;
    step(1);
    pio_in[5] = 1'b0;
    step(2);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tog = 1'b1;
    pio_in = 8'h80;
    rule_ready = 1'b0;
    #12;
    total += 3;
    if (rule_data !== 32'h0) begin
      bad++; $display("FAIL rst_data got=%h exp=0", rule_data);
    end
    if (rule_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", rule_valid);
    end
    if (status !== 8'h00) begin
      bad++; $display("FAIL rst_status got=%h exp=00", status);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    step(3);
    total += 2;
    if (status !== 8'h80) begin
      bad++; $display("FAIL arm_status got=%h exp=80", status);
    end
    if (rule_valid !== 1'b0) begin
      bad++; $display("FAIL arm_valid got=%b exp=0", rule_valid);
    end
  endtask

  task automatic test_reset_mid_frame;
    rule_ready = 1'b1;
    send_nib(4'h1, 1'b0);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    send_nib(4'h4, 1'b0);
    step(1);
    total++;
    if (status[1] !== 1'b1) begin
      bad++; $display("FAIL mid_collect got=%b exp=1", status[1]);
    end
    #2 reset_n = 1'b0;
    #2;
    total += 2;
    if (status !== 8'h00) begin
      bad++; $display("FAIL mid_rst_status got=%h exp=00", status);
    end
    if (rule_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_valid got=%b exp=0", rule_valid);
    end
    step(1);
    reset_n = 1'b1;
    step(3);
    total++;
    if (status !== 8'h80) begin
      bad++; $display("FAIL mid_rel_status got=%h exp=80", status);
    end
    exp_q.push_back(32'h0BADF00D);
    send_word(32'h0BADF00D);
    drain();
  endtask

  task automatic test_full_word;
    logic [31:0] w;
    int vcnt;
    w = 32'hDEADBEEF;
    rule_ready = 1'b1;
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      send_nib(w[4*i +: 4], i == 0);
      if (i != 0) begin
        step(1);
        total++;
        if (status[7] !== tog) begin
          bad++; $display("FAIL ack_nib%0d got=%b exp=%b", 7 - i, status[7], tog);
        end
      end
      if (i == 4) begin
        total++;
        if (status[1] !== 1'b1) begin
          bad++; $display("FAIL fw_collect got=%b exp=1", status[1]);
        end
      end
    end
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rule_valid === 1'b1) vcnt++;
    end
    total += 3;
    if (vcnt != 1) begin
      bad++; $display("FAIL fw_valid_cycles got=%0d exp=1", vcnt);
    end
    if (status[7] !== tog) begin
      bad++; $display("FAIL fw_ack_last got=%b exp=%b", status[7], tog);
    end
    if (status[4:2] !== 3'b000) begin
      bad++; $display("FAIL fw_errs got=%b exp=000", status[4:2]);
    end
    drain();
  endtask

  task automatic test_framing;
    int vcnt;
    rule_ready = 1'b1;
    vcnt = 0;
    send_nib(4'h1, 1'b0);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      if (rule_valid === 1'b1) vcnt++;
    end
    step(1);
    total += 2;
    if (status[2] !== 1'b1) begin
      bad++; $display("FAIL fr_early got=%b exp=1", status[2]);
    end
    if (vcnt != 0) begin
      bad++; $display("FAIL fr_no_valid got=%0d exp=0", vcnt);
    end
    clear_err();
    total++;
    if (status[2] !== 1'b0) begin
      bad++; $display("FAIL fr_clear got=%b exp=0", status[2]);
    end
    for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0);
    step(2);
    total += 2;
    if (status[2] !== 1'b1) begin
      bad++; $display("FAIL fr_nolast got=%b exp=1", status[2]);
    end
    if (status[1] !== 1'b0) begin
      bad++; $display("FAIL fr_idle got=%b exp=0", status[1]);
    end
    clear_err();
    exp_q.push_back(32'h00000001);
    send_word(32'h00000001);
    drain();
    total++;
    if (status[4:2] !== 3'b000) begin
      bad++; $display("FAIL fr_after got=%b exp=000", status[4:2]);
    end
  endtask

  task automatic test_overflow;
    rule_ready = 1'b0;
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678);
    send_word(32'hCAFEF00D);
    step(2);
    total += 3;
    if (rule_data !== 32'h12345678) begin
      bad++; $display("FAIL ovf_hold got=%h exp=12345678", rule_data);
    end
    if (status[3] !== 1'b1) begin
      bad++; $display("FAIL ovf_flag got=%b exp=1", status[3]);
    end
    if (rule_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_valid got=%b exp=1", rule_valid);
    end
    clear_err();
    total++;
    if (status[3] !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", status[3]);
    end
    rule_ready = 1'b1;
    drain();
    step(1);
    total++;
    if (rule_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_drained got=%b exp=0", rule_valid);
    end
  endtask

  task automatic test_timeout;
    rule_ready = 1'b1;
    send_nib(4'hA, 1'b0);
    send_nib(4'h5, 1'b0);
    send_nib(4'hA, 1'b0);
    step(T);
    total += 2;
    if (status[4] !== 1'b0) begin
      bad++; $display("FAIL to_early got=%b exp=0", status[4]);
    end
    if (status[1] !== 1'b1) begin
      bad++; $display("FAIL to_still got=%b exp=1", status[1]);
    end
    step(1);
    total += 2;
    if (status[4] !== 1'b1) begin
      bad++; $display("FAIL to_fire got=%b exp=1", status[4]);
    end
    if (status[1] !== 1'b0) begin
      bad++; $display("FAIL to_idle got=%b exp=0", status[1]);
    end
    clear_err();
    exp_q.push_back(32'hA5A5A5A5);
    send_nib(4'hA, 1'b0);
    send_nib(4'h5, 1'b0);
    send_nib(4'hA, 1'b0);
    step(T - 2);
    send_nib(4'h5, 1'b0);
    send_nib(4'hA, 1'b0);
    send_nib(4'h5, 1'b0);
    send_nib(4'hA, 1'b0);
    send_nib(4'h5, 1'b1);
    drain();
    total++;
    if (status[4] !== 1'b0) begin
      bad++; $display("FAIL to_boundary got=%b exp=0", status[4]);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] b;
    b = 32'h33334444;
    rule_ready = 1'b0;
    exp_q.push_back(32'h11112222);
    send_word(32'h11112222);
    for (int i = 7; i >= 1; i--) send_nib(b[4*i +: 4], 1'b0);
    send_nib(b[3:0], 1'b1);
    rule_ready = 1'b1;
    exp_q.push_back(b);
    step(1);
    rule_ready = 1'b0;
    total += 3;
    if (rule_valid !== 1'b1) begin
      bad++; $display("FAIL sim_valid got=%b exp=1", rule_valid);
    end
    if (rule_data !== b) begin
      bad++; $display("FAIL sim_data got=%h exp=%h", rule_data, b);
    end
    if (status[3] !== 1'b0) begin
      bad++; $display("FAIL sim_ovf got=%b exp=0", status[3]);
    end
    rule_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back;
    rule_ready = 1'b1;
    exp_q.push_back(32'h01234567);
    exp_q.push_back(32'h89ABCDEF);
    exp_q.push_back(32'hF0E1D2C3);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    send_word(32'hF0E1D2C3);
    drain();
    total++;
    if (status[4:2] !== 3'b000) begin
      bad++; $display("FAIL b2b_errs got=%b exp=000", status[4:2]);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_full_word();
    test_framing();
    test_overflow();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
